rr_bus_arbiter8: RTL and testbench

- Round-robin arbiter that shares one processor-internal resource (bus / register-file write port) among 8 requesters.
- Produces a registered 3-bit grant index plus the matching one-hot grant vector, which gates the requester's drivers.
- Sits between requesting units (ALU, load unit, I/O, etc.) and the shared resource.
- Ownership is held until the owner signals done or drops its request, then rotates fairly.

---
 rtl/rr_bus_arbiter8_pkg.sv | 19 +
 rtl/rr_bus_arbiter8_pick.sv | 31 +++
 rtl/rr_bus_arbiter8.sv | 113 +++++++++++
 tb/tb_rr_bus_arbiter8.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rr_bus_arbiter8_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin bus arbiter.
package rr_bus_arbiter8_pkg;

    localparam int unsigned NUM_REQ            = 8;
    localparam int unsigned IDX_W              = 3;
    localparam int unsigned CNT_W              = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // 3-to-8 decode used for the one-hot grant vector
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter8_pick.sv
// Combinational round-robin pick: rotate req by ptr, priority-encode, un-rotate.
module rr_priority_pick
    import rr_bus_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   pick_idx_o,
    output logic               any_req_o
);

    logic [NUM_REQ-1:0] rot_c;
    logic [IDX_W-1:0]   off_c;

    // rot_c[k] is requester (ptr + k) mod 8
    always_comb begin
        rot_c = (req_i >> ptr_i) | (req_i << (4'(NUM_REQ) - {1'b0, ptr_i}));
    end

    always_comb begin
        off_c = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                off_c = IDX_W'(i);
            end
        end
    end

    assign pick_idx_o = IDX_W'(ptr_i + off_c);
    assign any_req_o  = |req_i;

endmodule

// File: rtl/rr_bus_arbiter8.sv
// Round-robin arbiter for one shared internal resource among 8 requesters.
// Optional forced-release timeout enabled by defining ARB_TIMEOUT_EN.
module rr_bus_arbiter8
    import rr_bus_arbiter8_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               timeout_o
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             to_q, to_d;
    logic [IDX_W-1:0] pick_idx_c;
    logic             any_req_c;
    logic             expire_c;
    logic             release_c;

    rr_priority_pick u_pick (
        .req_i      (req_i),
        .ptr_i      (ptr_q),
        .pick_idx_o (pick_idx_c),
        .any_req_o  (any_req_c)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is zero in IDLE, so it starts at 0 on the first GRANT cycle
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_GRANT) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire_c = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        to_d      = 1'b0;
        release_c = done_i || !req_i[idx_q] || expire_c;
        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    state_d = ST_GRANT;
                    idx_d   = pick_idx_c;
                end
            end
            ST_GRANT: begin
                if (release_c) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    ptr_d   = IDX_W'(idx_q + IDX_W'(1));
                    // Pulse only when the timeout alone forced the release
                    to_d    = expire_c && !done_i && req_i[idx_q];
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            to_q    <= to_d;
        end
    end

    assign grant_valid_o = (state_q == ST_GRANT);
    assign grant_idx_o   = idx_q;
    assign gnt_o         = grant_valid_o ? idx_to_onehot(idx_q) : '0;
`ifdef ARB_TIMEOUT_EN
    assign timeout_o     = to_q;
`else
    assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Scoreboard bench for rr_bus_arbiter8: directed steps push expected outputs, a monitor compares.
module tb_rr_bus_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] gnt;
    logic       timeout;

    typedef struct {
        logic       valid;
        logic [2:0] idx;
        logic [7:0] gnt;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

`ifdef ARB_TIMEOUT_EN
    rr_bus_arbiter8 #(.TIMEOUT_CYCLES(4)) dut (
`else
    rr_bus_arbiter8 dut (
`endif
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .done_i        (done),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx),
        .gnt_o         (gnt),
        .timeout_o     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string name, input logic ev, input logic [2:0] ei,
                             input logic [7:0] eg, input logic et);
        n_vec++;
        if (grant_valid !== ev || grant_idx !== ei || gnt !== eg || timeout !== et) begin
            n_miss++;
            $display("FAIL %s: got valid=%0b idx=%0d gnt=%02h to=%0b, want valid=%0b idx=%0d gnt=%02h to=%0b",
                     name, grant_valid, grant_idx, gnt, timeout, ev, ei, eg, et);
        end
    endtask

    // Monitor: compare DUT outputs shortly after each edge against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_now("seq", e.valid, e.idx, e.gnt, e.to);
            end
        end
    end

    // Drive inputs at a falling edge; expectation holds after the next rising edge
    task automatic step(input logic [7:0] r, input logic d, input logic ev,
                        input logic [2:0] ei, input logic [7:0] eg, input logic et);
        exp_t e;
        req  = r;
        done = d;
        e.valid = ev;
        e.idx   = ei;
        e.gnt   = eg;
        e.to    = et;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] oh;
        int         guard;
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        #2;
        check_now("reset_async", 1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_now("reset_held", 1'b0, 3'd0, 8'h00, 1'b0);
        rst = 1'b0;

        // Single requester
        step(8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        step(8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        // Fairness from ptr=0 with all requesting
        do_reset();
        for (int k = 0; k < 9; k++) begin
            oh = 8'h01 << (k % 8);
            step(8'hFF, 1'b0, 1'b1, 3'(k % 8), oh, 1'b0);
            step(8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        end

        // Wrap: ptr=1 now
        step(8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0);
        step(8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        step(8'h81, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        step(8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        step(8'h81, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0);
        step(8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        // Release by dropping req, done ignored in IDLE, others ignored in GRANT (ptr=0)
        step(8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0);
        step(8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        step(8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        step(8'h10, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0);
        step(8'h12, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0);
        step(8'h02, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        step(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        step(8'h02, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        // Reset mid-grant (ptr=2)
        step(8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_mid_grant", 1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(8'h21, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        step(8'h21, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        // Hold behaviour with req=0x08 and no done (ptr=1)
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) step(8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
        step(8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        step(8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
        step(8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
`else
        for (int k = 0; k < 110; k++) step(8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
        step(8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
`endif
        step(8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
